// File: rtl/qf_tcm_pkg.sv
// Shared TCM definitions: access types, master IDs, default widths.
// Used by the DTCM arbiter (optional round-robin via DTCM_ARB_RR_EN).
package qf_tcm_pkg;

    localparam int AW_DEF = 18;
    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        RW_LB  = 3'b000,
        RW_LH  = 3'b001,
        RW_LW  = 3'b010,
        RW_LBU = 3'b100,
        RW_LHU = 3'b101
    } rw_type_e;

    localparam logic M0_CORE = 1'b0;
    localparam logic M1_LOAD = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter with clear, used for requester aging.
// Clear wins over increment; reset wins over both.
module arb_wait_counter #(
    parameter int W   = 8,
    parameter int MAX = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dtcm_arbiter.sv
// Two-master DTCM port arbiter: core (m0) vs loader/DMA (m1).
// Default m0 priority with aging; DTCM_ARB_RR_EN selects round-robin.
module dtcm_arbiter
    import qf_tcm_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 8,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_rw_type,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_rw_type,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_ren,
    output logic [2:0]    mem_rw_type,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    logic run;
    logic both_req;
    logic m1_win;
    logic g0;
    logic g1;

    assign run      = ~rst;
    assign both_req = m0_req & m1_req;

`ifdef DTCM_ARB_RR_EN
    // hist_q marks that someone has been served since reset, so the
    // very first contended cycle goes to m0.
    logic last_q;
    logic last_d;
    logic hist_q;
    logic hist_d;
    logic m1_pri;

    assign m1_pri = hist_q & (last_q == M0_CORE);
    assign m1_win = m1_req & (~m0_req | m1_pri);

    always_comb begin
        last_d = last_q;
        hist_d = hist_q;
        if (g1) begin
            last_d = M1_LOAD;
            hist_d = 1'b1;
        end else if (g0) begin
            last_d = M0_CORE;
            hist_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= M0_CORE;
            hist_q <= 1'b0;
        end else begin
            last_q <= last_d;
            hist_q <= hist_d;
        end
    end
`else
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    arb_wait_counter #(
        .W   (8),
        .MAX (MAX_WAIT)
    ) u_wait (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (m1_req & ~g1),
        .clr_i (g1 | ~m1_req),
        .cnt_o (wait_cnt)
    );

    assign m1_win = m1_req & (~m0_req | (wait_cnt == MAX_W));
`endif

    assign g1     = run & m1_win;
    assign g0     = run & m0_req & ~m1_win;
    assign m0_gnt = g0;
    assign m1_gnt = g1;

    always_comb begin
        mem_waddr   = '0;
        mem_raddr   = '0;
        mem_wdata   = '0;
        mem_rw_type = '0;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        unique case (1'b1)
            g1: begin
                mem_waddr   = m1_addr;
                mem_raddr   = m1_addr;
                mem_wdata   = m1_wdata;
                mem_rw_type = m1_rw_type;
                mem_wen     = m1_we;
                mem_ren     = ~m1_we;
            end
            g0: begin
                mem_waddr   = m0_addr;
                mem_raddr   = m0_addr;
                mem_wdata   = m0_wdata;
                mem_rw_type = m0_rw_type;
                mem_wen     = m0_we;
                mem_ren     = ~m0_we;
            end
            default: ;
        endcase
    end

    // Read response tracking: one-cycle DTCM latency.
    logic rsp_valid_q;
    logic rsp_valid_d;
    logic rsp_owner_q;
    logic rsp_owner_d;

    assign rsp_valid_d = (g0 & ~m0_we) | (g1 & ~m1_we);
    assign rsp_owner_d = g1 ? M1_LOAD : M0_CORE;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= M0_CORE;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign m0_rvalid = run & rsp_valid_q & (rsp_owner_q == M0_CORE);
    assign m1_rvalid = run & rsp_valid_q & (rsp_owner_q == M1_LOAD);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

    logic [CW-1:0] cc_q;
    logic [CW-1:0] cc_d;

    always_comb begin
        cc_d = cc_q;
        if (both_req && (cc_q != {CW{1'b1}})) begin
            cc_d = cc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign conflict_cnt = cc_q;

endmodule
